// File: rtl/key_event_capture_if.sv
// Keypad event capture bus: scan-FSM press/data in, MCU-facing FIFO read port and status out.
interface key_event_capture_if;
  logic       press;
  logic [3:0] data;
  logic       key_rd;
  logic       clr_ovf;
  logic       key_valid;
  logic [3:0] key_code;
  logic       overflow;
  logic       intr;

  modport master (
    output press, data, key_rd, clr_ovf,
    input  key_valid, key_code, overflow, intr
  );

  modport slave (
    input  press, data, key_rd, clr_ovf,
    output key_valid, key_code, overflow, intr
  );
endinterface

// File: rtl/key_event_capture.sv
// Debounces keypad presses, queues one code per physical press in a FWFT FIFO for the MCU.
// Optional one-cycle INTR pulse per accepted key when KEY_EVENT_INTR_EN is defined.
module key_event_capture #(
  parameter int unsigned DebounceCycles = 16,
  parameter int unsigned FifoDepth      = 4
) (
  input logic              clk,
  input logic              rst_n,
  key_event_capture_if.slave bus
);

  localparam int unsigned CntW  = $clog2(DebounceCycles + 1);
  localparam int unsigned AddrW = $clog2(FifoDepth);
  localparam logic [CntW-1:0] CntLast  = CntW'(DebounceCycles - 1);
  localparam logic [3:0]      CodeNone = 4'd13;
  localparam logic [3:0]      CodeMax  = 4'd11;

  typedef enum logic [1:0] {StIdle, StDebPress, StHeld, StDebRel} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cand_q, cand_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            push_req;
  logic            code_ok;

  assign code_ok = bus.data <= CodeMax;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cand_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    push_req = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.press && code_ok) begin
          cand_d  = bus.data;
          cnt_d   = CntW'(1);
          state_d = StDebPress;
        end
      end
      StDebPress: begin
        if (!bus.press || !code_ok) begin
          state_d = StIdle;
        end else if (bus.data != cand_q) begin
          // A different valid code restarts debounce on this very sample.
          cand_d = bus.data;
          cnt_d  = CntW'(1);
        end else if (cnt_q == CntLast) begin
          push_req = 1'b1;
          state_d  = StHeld;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHeld: begin
        if (!bus.press) begin
          cnt_d   = CntW'(1);
          state_d = StDebRel;
        end
      end
      StDebRel: begin
        if (bus.press) begin
          state_d = StHeld;
        end else if (cnt_q == CntLast) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  logic [3:0]     mem_q [FifoDepth];
  logic [AddrW:0] wr_ptr_q, rd_ptr_q;
  logic           empty, full, pop, push_en;
  logic           overflow_q;

  assign empty   = wr_ptr_q == rd_ptr_q;
  assign full    = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign pop     = bus.key_rd && !empty;
  // A pop on the same edge frees the slot, so a full FIFO can still take the push.
  assign push_en = push_req && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_req && full && !pop) begin
        overflow_q <= 1'b1;
      end else if (bus.clr_ovf) begin
        overflow_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q[AddrW-1:0]] <= cand_q;
  end

  assign bus.key_valid = !empty;
  assign bus.key_code  = empty ? CodeNone : mem_q[rd_ptr_q[AddrW-1:0]];
  assign bus.overflow  = overflow_q;

`ifdef KEY_EVENT_INTR_EN
  logic intr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      intr_q <= 1'b0;
    end else begin
      intr_q <= push_req;
    end
  end

  assign bus.intr = intr_q;
`else
  assign bus.intr = 1'b0;
`endif

endmodule

// File: tb/tb_key_event_capture.sv
// Directed bench for key_event_capture with a queue-based scoreboard of expected FIFO contents.
module tb_key_event_capture;

  localparam int unsigned Dc    = 4;
  localparam int unsigned Depth = 4;
`ifdef KEY_EVENT_INTR_EN
  localparam logic IntrExp = 1'b1;
`else
  localparam logic IntrExp = 1'b0;
`endif

  logic clk;
  logic rst_n;

  key_event_capture_if bus ();

  key_event_capture #(
    .DebounceCycles(Dc),
    .FifoDepth     (Depth)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int intr_seen = 0;

  logic [3:0] exp_q[$];
  logic       exp_ovf = 1'b0;

  always @(negedge clk) begin
    if (bus.intr === 1'b1) intr_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_empty(input string tag);
    chk({tag, "_valid"}, 32'(bus.key_valid), 32'd0);
    chk({tag, "_code"}, 32'(bus.key_code), 32'd13);
  endtask

  // Full press: debounce, optional pop/clear on the accept edge, hold, debounced release.
  task automatic press_key(input logic [3:0] code, input bit rd_on_accept,
                           input bit clr_on_accept, input int hold);
    bus.press = 1'b1;
    bus.data  = code;
    repeat (Dc - 1) tick();
    bus.key_rd  = rd_on_accept;
    bus.clr_ovf = clr_on_accept;
    if (rd_on_accept && exp_q.size() > 0) begin
      chk("head_at_accept", 32'(bus.key_code), 32'(exp_q[0]));
      void'(exp_q.pop_front());
    end
    if (exp_q.size() < Depth) exp_q.push_back(code);
    else exp_ovf = 1'b1;
    tick();
    bus.key_rd  = 1'b0;
    bus.clr_ovf = 1'b0;
    chk("accept_intr", 32'(bus.intr), 32'(IntrExp));
    chk("accept_overflow", 32'(bus.overflow), 32'(exp_ovf));
    chk("accept_valid", 32'(bus.key_valid), 32'd1);
    repeat (hold) tick();
    bus.press = 1'b0;
    bus.data  = 4'd13;
    tick();
    chk("intr_single", 32'(bus.intr), 32'd0);
    repeat (Dc - 1) tick();
  endtask

  task automatic pop_check(input string tag);
    logic [3:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'd13;
    chk({tag, "_valid"}, 32'(bus.key_valid), 32'd1);
    chk({tag, "_code"}, 32'(bus.key_code), 32'(e));
    bus.key_rd = 1'b1;
    tick();
    bus.key_rd = 1'b0;
  endtask

  initial begin
    int base;
    logic pattern [8];
    pattern = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    rst_n       = 1'b0;
    bus.press   = 1'b0;
    bus.data    = 4'd13;
    bus.key_rd  = 1'b0;
    bus.clr_ovf = 1'b0;
    #2;
    check_empty("reset");
    chk("reset_overflow", 32'(bus.overflow), 32'd0);
    chk("reset_intr", 32'(bus.intr), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Single press of 5, KEY_RD asserted while still empty on the accept edge.
    base = intr_seen;
    bus.press  = 1'b1;
    bus.data   = 4'd5;
    repeat (Dc - 1) tick();
    check_empty("pre_accept");
    bus.press = 1'b0;
    repeat (Dc) tick();
    press_key(4'd5, 1'b1, 1'b0, 100);
    chk("code5_head", 32'(bus.key_code), 32'd5);
    pop_check("read5");
    check_empty("after5");
    chk("intr_count5", 32'(intr_seen - base), 32'(IntrExp));

    // Bouncing press never reaches the accept count.
    bus.data = 4'd7;
    for (int i = 0; i < 8; i++) begin
      bus.press = pattern[i];
      tick();
      check_empty("bounce");
    end
    bus.press = 1'b0;
    repeat (Dc) tick();

    // Code change mid-debounce restarts on the new code.
    bus.press = 1'b1;
    bus.data  = 4'd7;
    tick();
    tick();
    bus.data = 4'd8;
    repeat (3) tick();
    check_empty("restart_pre");
    tick();
    exp_q.push_back(4'd8);
    chk("restart_valid", 32'(bus.key_valid), 32'd1);
    chk("restart_code", 32'(bus.key_code), 32'd8);
    bus.press = 1'b0;
    bus.data  = 4'd13;
    repeat (Dc) tick();
    pop_check("read8");
    check_empty("after8");

    // Overflow: fifth key dropped; sixth dropped while CLR_OVF is high (set wins).
    press_key(4'd1, 1'b0, 1'b0, 2);
    press_key(4'd2, 1'b0, 1'b0, 2);
    press_key(4'd3, 1'b0, 1'b0, 2);
    press_key(4'd4, 1'b0, 1'b0, 2);
    chk("full_no_ovf", 32'(bus.overflow), 32'd0);
    press_key(4'd6, 1'b0, 1'b0, 2);
    press_key(4'd7, 1'b0, 1'b1, 2);
    chk("ovf_set", 32'(bus.overflow), 32'd1);
    for (int i = 0; i < 4; i++) pop_check("ovf_read");
    check_empty("ovf_drained");
    bus.clr_ovf = 1'b1;
    tick();
    bus.clr_ovf = 1'b0;
    exp_ovf = 1'b0;
    chk("ovf_cleared", 32'(bus.overflow), 32'd0);

    // Push into full FIFO on the same edge as a pop.
    press_key(4'd1, 1'b0, 1'b0, 2);
    press_key(4'd2, 1'b0, 1'b0, 2);
    press_key(4'd3, 1'b0, 1'b0, 2);
    press_key(4'd4, 1'b0, 1'b0, 2);
    press_key(4'd9, 1'b1, 1'b0, 2);
    chk("simul_no_ovf", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < 4; i++) pop_check("simul_read");
    check_empty("simul_drained");

    // Asynchronous reset on debounce edge 3 with two codes queued.
    press_key(4'd3, 1'b0, 1'b0, 1);
    press_key(4'd4, 1'b0, 1'b0, 1);
    bus.press = 1'b1;
    bus.data  = 4'd2;
    repeat (3) tick();
    chk("prereset_valid", 32'(bus.key_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check_empty("async_reset");
    chk("async_reset_ovf", 32'(bus.overflow), 32'd0);
    exp_q.delete();
    exp_ovf = 1'b0;
    #1;
    rst_n = 1'b1;
    repeat (Dc - 1) tick();
    check_empty("post_reset_deb");
    tick();
    exp_q.push_back(4'd2);
    chk("post_reset_valid", 32'(bus.key_valid), 32'd1);
    chk("post_reset_code", 32'(bus.key_code), 32'd2);
    bus.press = 1'b0;
    bus.data  = 4'd13;
    repeat (Dc) tick();
    pop_check("read2");
    check_empty("final");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
